// File: rtl/block_map_module.sv
`default_nettype none
// ============================================================================
// Module   : block_map_module
// Brief    : Arena block map (one bit per tile) with LFSR fill, clear port,
//            pixel lookup, tile collision query and remaining-block count.
// Revision : 1.0 - initial release
// ============================================================================
module block_map_module #(
    parameter int          MAP_W     = 33,
    parameter int          MAP_H     = 27,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          DENSITY   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       regen,
    input  logic [9:0] x_a,
    input  logic [9:0] y_a,
    input  logic [9:0] block_w_addr,
    input  logic       block_we,
    input  logic [5:0] q_x,
    input  logic [5:0] q_y,
    output logic       block_on,
    output logic       pillar_on,
    output logic       q_blocked,
    output logic [9:0] blocks_left,
    output logic       init_done
);

    localparam int         c_TILES      = MAP_W * MAP_H;
    localparam logic [5:0] c_LAST_X     = 6'(MAP_W - 1);
    localparam logic [5:0] c_LAST_Y     = 6'(MAP_H - 1);
    localparam logic [9:0] c_TILES_ADDR = 10'(c_TILES);
    localparam logic [4:0] c_DENSITY    = 5'(DENSITY);

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    function automatic logic [9:0] tile_addr(input logic [5:0] tx, input logic [5:0] ty);
        tile_addr = {4'd0, tx} + ({4'd0, ty} << 5) + {4'd0, ty};
    endfunction

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [5:0]         r_x;
    logic [5:0]         r_y;
    logic [9:0]         r_addr;
    logic [15:0]        r_lfsr;
    logic [9:0]         r_blocks_left;
    logic [c_TILES-1:0] r_map;

    logic       w_init;
    logic       w_spawn;
    logic       w_gen_bit;
    logic       w_fb;
    logic       w_init_last;
    logic       w_clr;
    logic       w_map_we;
    logic [9:0] w_map_waddr;
    logic       w_map_wdata;

    logic [5:0] w_px_tx;
    logic [5:0] w_px_ty;
    logic       w_px_in;
    logic [9:0] w_px_addr;
    logic       w_q_in;
    logic [9:0] w_q_addr;
    logic       w_unused_pix_lsbs;

    assign w_init      = (r_state == c_ST_INIT);
    assign w_spawn     = ((r_y == 6'd0) && (r_x <= 6'd1)) || ((r_x == 6'd0) && (r_y == 6'd1));
    assign w_gen_bit   = ({1'b0, r_lfsr[3:0]} < c_DENSITY) && !(r_x[0] && r_y[0]) && !w_spawn;
    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_init_last = (r_x == c_LAST_X) && (r_y == c_LAST_Y);

    // A clear only counts when the bit is still set, so a held write decrements once.
    assign w_clr = !w_init && block_we && (block_w_addr < c_TILES_ADDR)
                   && r_map[block_w_addr] && (r_blocks_left != 10'd0);

    assign w_map_we    = reset && !regen && (w_init || w_clr);
    assign w_map_waddr = w_init ? r_addr : block_w_addr;
    assign w_map_wdata = w_init ? w_gen_bit : 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        if (regen) begin
            w_state_nxt = c_ST_INIT;
        end else if (w_init && w_init_last) begin
            w_state_nxt = c_ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_ST_INIT;
            r_x           <= 6'd0;
            r_y           <= 6'd0;
            r_addr        <= 10'd0;
            r_lfsr        <= LFSR_SEED;
            r_blocks_left <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            if (regen) begin
                r_x           <= 6'd0;
                r_y           <= 6'd0;
                r_addr        <= 10'd0;
                r_lfsr        <= LFSR_SEED;
                r_blocks_left <= 10'd0;
            end else if (w_init) begin
                r_lfsr <= {r_lfsr[14:0], w_fb};
                r_addr <= r_addr + 10'd1;
                if (w_gen_bit) begin
                    r_blocks_left <= r_blocks_left + 10'd1;
                end
                if (r_x == c_LAST_X) begin
                    r_x <= 6'd0;
                    r_y <= r_y + 6'd1;
                end else begin
                    r_x <= r_x + 6'd1;
                end
            end else if (w_clr) begin
                r_blocks_left <= r_blocks_left - 10'd1;
            end
        end
    end

    // Every tile is rewritten during INIT, so the map itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_map_we) begin
            r_map[w_map_waddr] <= w_map_wdata;
        end
    end

    assign w_px_tx           = x_a[9:4];
    assign w_px_ty           = y_a[9:4];
    assign w_px_in           = (w_px_tx <= c_LAST_X) && (w_px_ty <= c_LAST_Y);
    assign w_px_addr         = tile_addr(w_px_tx, w_px_ty);
    assign w_q_in            = (q_x <= c_LAST_X) && (q_y <= c_LAST_Y);
    assign w_q_addr          = tile_addr(q_x, q_y);
    assign w_unused_pix_lsbs = ^{x_a[3:0], y_a[3:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            block_on  <= 1'b0;
            pillar_on <= 1'b0;
            q_blocked <= 1'b1;
        end else begin
            block_on  <= !w_init && w_px_in && r_map[w_px_addr];
            pillar_on <= w_px_in && w_px_tx[0] && w_px_ty[0];
            q_blocked <= w_init || !w_q_in || (q_x[0] && q_y[0]) || r_map[w_q_addr];
        end
    end

    assign blocks_left = r_blocks_left;
    assign init_done   = (r_state == c_ST_READY);

endmodule
`default_nettype wire
